modulo_unit_param: RTL and testbench

Parametrised, self-sequenced modulo unit that computes the remainder and quotient of two unsigned WIDTH-bit operands using restoring shift-subtract division. It is the next generation of the modulo datapath. The external control-flag interface is replaced by an internal FSM and a start/busy/valid handshake. It adds an early-out path for dividend < divisor and explicit divide-by-zero reporting. The block sits between the operand source and the result consumer as a single-request, non-pipelined functional unit.

---
 rtl/modulo_unit_param_pkg.sv | 20 ++
 rtl/modulo_unit_param_if.sv | 29 ++
 rtl/modulo_unit_param_mod_step.sv | 36 +++
 rtl/modulo_unit_param.sv | 150 +++++++++++++++
 tb/tb_modulo_unit_param.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/modulo_unit_param_pkg.sv
// Shared definitions for the modulo unit: FSM state encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modulo_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] ITER  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int MOD_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_CHECK = CHECK,
    ST_ITER  = ITER,
    ST_DONE  = DONE
  } state_t;

endpackage

// File: rtl/modulo_unit_param_if.sv
// Request/result bundle between the operand source and the modulo unit.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while busy_o is low; no queueing.
interface modulo_unit_param_if #(
  parameter int WIDTH = 16
);

  logic             start_i;
  logic [WIDTH-1:0] Zahl1_i;
  logic [WIDTH-1:0] Zahl2_i;
  logic [WIDTH-1:0] ergebnis;
  logic [WIDTH-1:0] quotient_o;
  logic             valid_o;
  logic             busy_o;
  logic             err_o;

  // Operand source side.
  modport master (
    output start_i, Zahl1_i, Zahl2_i,
    input  ergebnis, quotient_o, valid_o, busy_o, err_o
  );

  // Modulo unit side.
  modport slave (
    input  start_i, Zahl1_i, Zahl2_i,
    output ergebnis, quotient_o, valid_o, busy_o, err_o
  );

endinterface

// File: rtl/modulo_unit_param_mod_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only during iteration.
module mod_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_r,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_div_ext;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_shift   = {i_r[WIDTH-1:0], i_q_msb};
  assign w_div_ext = {1'b0, i_div};
  assign w_diff    = w_shift - w_div_ext;
  // A set top bit of r would shift out as a carry and guarantees the trial
  // subtraction succeeds; with r < divisor held invariant it stays zero.
  assign w_ge      = i_r[WIDTH] | (w_shift >= w_div_ext);

  // Restore (keep the shifted value) when the trial subtraction would go negative.
  always_comb begin
    o_r     = w_shift;
    o_q_bit = 1'b0;
    if (w_ge) begin
      o_r     = w_diff;
      o_q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/modulo_unit_param.sv
// Self-sequenced unsigned divider returning remainder (ergebnis) and quotient.
// Latency: WIDTH+2 cycles start-to-valid; 2 cycles for divide-by-zero or dividend < divisor.
// Backpressure: single request in flight; start_i ignored while busy_o, no queueing.
module modulo_unit_param
  import modulo_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH_DEFAULT
) (
  input logic                clk,
  input logic                rst_i,
  modulo_unit_param_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_ergebnis;
  logic [WIDTH-1:0] r_quotient;
  logic             r_err;

  logic             w_start_acc;
  logic             w_div_zero;
  logic             w_early;
  logic             w_last;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_start_acc = (r_state == ST_IDLE) && bus.start_i;
  assign w_div_zero  = (r_divisor == '0);
  assign w_early     = (r_dividend < r_divisor);
  assign w_last      = (r_cnt == '0);
  assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_q_bit};

  mod_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r    (r_rem),
    .i_q_msb(r_quo[WIDTH-1]),
    .i_div  (r_divisor),
    .o_r    (w_rem_nxt),
    .o_q_bit(w_q_bit)
  );

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: short paths skip ITER, ITER runs until the counter hits zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_div_zero || w_early) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ITER;
        end
      end
      ST_ITER: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers. Results are
  // written on the edge that enters DONE so they are already stable while
  // valid_o is high, then held until the next completion.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_ergebnis <= '0;
      r_quotient <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_acc) begin
            r_dividend <= bus.Zahl1_i;
            r_divisor  <= bus.Zahl2_i;
            r_err      <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (w_div_zero) begin
            r_err      <= 1'b1;
            r_ergebnis <= r_dividend;
            r_quotient <= '1;
          end else if (w_early) begin
            r_ergebnis <= r_dividend;
            r_quotient <= '0;
          end else begin
            r_rem <= '0;
            r_quo <= r_dividend;
            r_cnt <= CNT_W'(WIDTH - 1);
          end
        end
        ST_ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (w_last) begin
            r_ergebnis <= w_rem_nxt[WIDTH-1:0];
            r_quotient <= w_quo_nxt;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ergebnis   = r_ergebnis;
  assign bus.quotient_o = r_quotient;
  assign bus.err_o      = r_err;
  assign bus.valid_o    = (r_state == ST_DONE);
  assign bus.busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_modulo_unit_param.sv
// Bench for modulo_unit_param: 16-bit and 8-bit instances, directed and random requests.
// Latency: results compared against an arithmetic model including start-to-valid edge count.
// Backpressure: starts injected while busy must be ignored.
module tb_modulo_unit_param;

  logic clk = 1'b0;
  logic rst_i;

  always #5 clk = ~clk;

  modulo_unit_param_if #(.WIDTH(16)) if16 ();
  modulo_unit_param_if #(.WIDTH(8))  if8 ();

  modulo_unit_param #(.WIDTH(16)) u_dut16 (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (if16.slave)
  );

  modulo_unit_param #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (if8.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit          cur8 = 1'b0;
  logic [31:0] o_erg;
  logic [31:0] o_quo;
  logic        o_val;
  logic        o_busy;
  logic        o_err;

  always_comb begin
    o_erg  = 32'(if16.ergebnis);
    o_quo  = 32'(if16.quotient_o);
    o_val  = if16.valid_o;
    o_busy = if16.busy_o;
    o_err  = if16.err_o;
    if (cur8) begin
      o_erg  = 32'(if8.ergebnis);
      o_quo  = 32'(if8.quotient_o);
      o_val  = if8.valid_o;
      o_busy = if8.busy_o;
      o_err  = if8.err_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel8, input logic st, input logic [31:0] a, input logic [31:0] b);
    if (sel8) begin
      if8.start_i = st;
      if8.Zahl1_i = a[7:0];
      if8.Zahl2_i = b[7:0];
    end else begin
      if16.start_i = st;
      if16.Zahl1_i = a[15:0];
      if16.Zahl2_i = b[15:0];
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ergebnis"}, o_erg, 32'd0);
    chk({tag, "_quotient"}, o_quo, 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_valid"}, 32'(o_val), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  // One request. inj_k > 0 pulses a stray start before edge E0+inj_k;
  // rst_k > 0 applies reset at edge E0+rst_k instead of letting it complete.
  task automatic op(input bit sel8, input logic [31:0] a_in, input logic [31:0] b_in,
                    input int inj_k, input int rst_k);
    int          w;
    int          k;
    int          vhits;
    bit          seen;
    logic [31:0] mask;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic [31:0] exp_q;
    logic        exp_err;
    int          exp_k;

    cur8 = sel8;
    w    = sel8 ? 8 : 16;
    mask = (32'd1 << w) - 32'd1;
    a    = a_in & mask;
    b    = b_in & mask;

    // Reference: plain integer division, with the zero-divisor convention.
    if (b == 0) begin
      exp_r   = a;
      exp_q   = mask;
      exp_err = 1'b1;
      exp_k   = 1;
    end else begin
      exp_r   = a % b;
      exp_q   = a / b;
      exp_err = 1'b0;
      exp_k   = (a < b) ? 1 : w + 1;
    end

    drive(sel8, 1'b1, a, b);
    @(posedge clk);
    #1;
    drive(sel8, 1'b0, 32'd0, 32'd0);
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("err_cleared_on_start", 32'(o_err), 32'd0);

    seen = 1'b0;
    k    = 0;
    while (!seen && k < 60) begin
      if (k + 1 == inj_k) drive(sel8, 1'b1, 32'd3, 32'd2);
      if (k + 1 == rst_k) rst_i = 1'b1;
      @(posedge clk);
      #1;
      k++;
      drive(sel8, 1'b0, 32'd0, 32'd0);
      if (rst_i) begin
        rst_i = 1'b0;
        check_all_zero("mid_op_reset");
        vhits = 0;
        for (int i = 0; i < 30; i++) begin
          @(posedge clk);
          #1;
          if (o_val) vhits++;
        end
        chk("no_valid_after_reset", 32'(vhits), 32'd0);
        return;
      end
      if (o_val) seen = 1'b1;
    end

    chk("valid_latency", 32'(k), 32'(exp_k));
    if (seen) begin
      chk("ergebnis", o_erg, exp_r);
      chk("quotient", o_quo, exp_q);
      chk("err", 32'(o_err), 32'(exp_err));
      chk("busy_in_done", 32'(o_busy), 32'd1);
      @(posedge clk);
      #1;
      chk("valid_single_pulse", 32'(o_val), 32'd0);
      chk("busy_low_after_done", 32'(o_busy), 32'd0);
      chk("ergebnis_hold", o_erg, exp_r);
      chk("quotient_hold", o_quo, exp_q);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    cur8 = 1'b0;
    check_all_zero("reset16");
    cur8 = 1'b1;
    check_all_zero("reset8");

    // Reset must dominate a start sampled on the same edge.
    cur8 = 1'b0;
    drive(1'b0, 1'b1, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_beats_start_busy", 32'(o_busy), 32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, 16-bit.
    op(1'b0, 32'd100,    32'd7,   0, 0);
    op(1'b0, 32'd5,      32'd9,   0, 0);
    op(1'b0, 32'd300,    32'd300, 0, 0);
    op(1'b0, 32'd1234,   32'd0,   0, 0);
    op(1'b0, 32'd100,    32'd7,   0, 0);
    op(1'b0, 32'hFFFF,   32'd1,   5, 0);
    op(1'b0, 32'd100,    32'd7,   0, 5);
    op(1'b0, 32'd50,     32'd8,   0, 0);
    op(1'b0, 32'hFFFF,   32'hFFFF, 0, 0);
    op(1'b0, 32'd0,      32'd3,   0, 0);

    // Directed cases, 8-bit.
    op(1'b1, 32'd200,    32'd13,  0, 0);
    op(1'b1, 32'd255,    32'd0,   0, 0);
    op(1'b1, 32'd7,      32'd200, 2, 0);

    // Random requests with a bias toward the interesting divisor classes.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      op(i[0], ra, rb, (i % 7 == 3) ? 4 : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
